shift_capture_ctrl: RTL

SHIFT_CAPTURE_CTRL -- requirements
Module: shift_capture_ctrl

---
 rtl/shift_capture_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_capture_ctrl.sv
// Frame controller for an external 8-bit serial-in shift register: clears it,
// shifts FRAME_BITS serial bits in MSB-first, then captures the parallel value.
module shift_capture_ctrl #(
    parameter int FRAME_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       serial_in,
    input  logic [7:0] sr_data,
    input  logic       out_ready,
    input  logic       clear_overrun,
    output logic       sr_reset_n,
    output logic       sr_shift_enable,
    output logic       sr_data_in,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       overrun,
    output logic [1:0] fsm_state
);

    // Output handshake: a frame is transferred on any edge where out_valid and
    // out_ready are both high; out_data holds steady until that edge.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        SHIFT   = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(FRAME_BITS - 1);
    localparam logic [7:0] FRAME_MASK = 8'((9'd1 << FRAME_BITS) - 9'd1);

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic [3:0] count_next;
    logic       capture;
    logic       drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                count_next = 4'd0;
                state_next = SHIFT;
            end
            SHIFT: begin
                // Counter parks at the last index rather than wrapping past it.
                if (count == LAST_COUNT) begin
                    state_next = CAPTURE;
                end else begin
                    count_next = count + 4'd1;
                end
            end
            CAPTURE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    assign sr_reset_n      = !reset && (state != CLEAR);
    assign sr_shift_enable = !reset && (state == SHIFT);
    assign sr_data_in      = (state == SHIFT) ? serial_in : 1'b0;
    assign busy            = !reset && (state != IDLE);
    assign fsm_state       = state;

    assign capture = (state == CAPTURE);
    assign drop    = capture && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            if (capture) begin
                if (!drop) begin
                    out_data  <= sr_data & FRAME_MASK;
                    out_valid <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A drop on the same edge as a clear leaves the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
